// File: rtl/ppm_pkg.sv
// ---------------------------------------------------------------------------
// ppm_pkg
// Shared constants for the PPM/servo output bank: control/status register
// bit positions, the frame counter field offset and a helper returning the
// register offset of the control register for a given channel count.
// No ports (package).
// ---------------------------------------------------------------------------
package ppm_pkg;

    // Control/status register bit positions
    localparam int CTRL_ARM_BIT      = 0;
    localparam int CTRL_FAILSAFE_BIT = 1;
    localparam int CTRL_ARMED_BIT    = 2;

    // LSB of the 16-bit frame counter field in the status readback
    localparam int FRAME_CNT_LSB     = 16;

    // The control register sits directly after the last channel register
    function automatic int ctrl_offset(input int channels);
        return channels;
    endfunction

endpackage

// File: rtl/ppm_timebase.sv
// ---------------------------------------------------------------------------
// ppm_timebase
// Microsecond timebase for the PPM bank. A prescaler divides the CPU clock
// down to a 1 us tick, us_cnt counts ticks through one frame and wraps, and
// frame_start pulses for one clock on the tick where us_cnt wraps to 0.
// A free-running 16-bit frame counter advances on every frame start.
//
// Ports:
//   clk         in   CPU clock
//   rst_n       in   asynchronous active-low reset
//   us_cnt      out  current microsecond position in the frame (registered)
//   frame_start out  one-cycle pulse, high in the cycle before us_cnt wraps
//   frame_cnt   out  frame counter modulo 2^16 (registered)
// ---------------------------------------------------------------------------
module ppm_timebase #(
    parameter int TICK_DIV = 50,
    parameter int FRAME_US = 20000,
    localparam int US_W    = $clog2(FRAME_US)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [US_W-1:0] us_cnt,
    output logic            frame_start,
    output logic [15:0]     frame_cnt
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick        = (pre_cnt == PW'(TICK_DIV - 1));
    assign frame_start = tick && (us_cnt == US_W'(FRAME_US - 1));

    // Prescaler, microsecond counter and frame counter. frame_start is
    // combinational so that everything latched "at frame start" in the
    // parent updates on the same edge as us_cnt wrapping to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            us_cnt    <= '0;
            frame_cnt <= '0;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end

            if (frame_start) begin
                us_cnt    <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (tick) begin
                us_cnt <= us_cnt + US_W'(1);
            end
        end
    end

endmodule

// File: rtl/ppm_bank.sv
// ---------------------------------------------------------------------------
// ppm_bank
// Multi-channel PPM/servo pulse generator on the CPU data bus. Each channel
// has a shadow register written by the bus (clamped to MAX_VAL) and an
// active register loaded from the shadow at every frame start, so a pulse
// never changes mid-frame. An ARM bit gates all outputs from the next frame
// start. A write watchdog forces all channels to minimum throttle when no
// channel has been written for WDOG_FRAMES consecutive frames.
//
// Ports:
//   CLK       in   CPU clock, sole clock
//   RESET_N   in   asynchronous active-low reset
//   WE        in   bus write strobe, one cycle per write
//   ADDR      in   0..CHANNELS-1 channel values, CHANNELS control/status
//   WD        in   32-bit write data
//   RD        out  combinational read data for ADDR
//   PPM       out  registered pulse outputs, one per channel
//   FAILSAFE  out  high while the watchdog has tripped
// ---------------------------------------------------------------------------
module ppm_bank
    import ppm_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int VAL_W       = 10,
    parameter int MAX_VAL     = 1000,
    parameter int TICK_DIV    = 50,
    parameter int MIN_US      = 1000,
    parameter int FRAME_US    = 20000,
    parameter int WDOG_FRAMES = 25,
    localparam int AW         = $clog2(CHANNELS + 1)
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                WE,
    input  logic [AW-1:0]       ADDR,
    input  logic [31:0]         WD,
    output logic [31:0]         RD,
    output logic [CHANNELS-1:0] PPM,
    output logic                FAILSAFE
);

    localparam int US_W = $clog2(FRAME_US);
    localparam int WW   = $clog2(WDOG_FRAMES + 1);

    localparam logic [AW-1:0]    CTRL_ADDR = AW'(ctrl_offset(CHANNELS));
    localparam logic [VAL_W-1:0] MAX_V     = VAL_W'(MAX_VAL);
    localparam logic [WW-1:0]    WDOG_LIM  = WW'(WDOG_FRAMES);

    // Reject parameter sets that cannot produce a sane frame
    if (FRAME_US <= MIN_US + MAX_VAL) begin : g_bad_frame
        $error("ppm_bank: FRAME_US must exceed MIN_US + MAX_VAL");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("ppm_bank: CHANNELS must be in 1..16");
    end
    if (VAL_W < 1 || VAL_W > 32 || MAX_VAL >= (64'd1 << VAL_W)) begin : g_bad_val
        $error("ppm_bank: MAX_VAL must fit in VAL_W bits (VAL_W <= 32)");
    end
    if (TICK_DIV < 1 || WDOG_FRAMES < 1) begin : g_bad_div
        $error("ppm_bank: TICK_DIV and WDOG_FRAMES must be at least 1");
    end

    logic [VAL_W-1:0]    shadow [CHANNELS];
    logic [VAL_W-1:0]    act    [CHANNELS];
    logic                arm;
    logic                armed_act;
    logic                failsafe;
    logic [WW-1:0]       wd_cnt;
    logic [WW-1:0]       wd_inc;
    logic [US_W-1:0]     us_cnt;
    logic                frame_start;
    logic [15:0]         frame_cnt;
    logic                chan_we;
    logic                ctrl_we;
    logic [VAL_W-1:0]    wr_raw;
    logic [VAL_W-1:0]    wr_val;
    logic [CHANNELS-1:0] ppm_next;
    logic [CHANNELS-1:0] ppm_q;
    logic [31:0]         rd_data;
    logic                unused_wd;

    ppm_timebase #(
        .TICK_DIV (TICK_DIV),
        .FRAME_US (FRAME_US)
    ) u_timebase (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .us_cnt      (us_cnt),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    assign chan_we   = WE && (ADDR < CTRL_ADDR);
    assign ctrl_we   = WE && (ADDR == CTRL_ADDR);
    assign wr_raw    = WD[VAL_W-1:0];
    assign wr_val    = (wr_raw > MAX_V) ? MAX_V : wr_raw;
    assign wd_inc    = (wd_cnt == WDOG_LIM) ? wd_cnt : wd_cnt + WW'(1);
    assign unused_wd = &{1'b0, WD};

    // Register file, frame latch and watchdog. The frame latch uses the
    // registered failsafe, so the frame on which the watchdog trips still
    // carries normal values and minimum throttle starts one frame later.
    // A channel write on the expiry frame start takes priority over the
    // watchdog increment.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                act[i]    <= '0;
            end
            arm       <= 1'b0;
            armed_act <= 1'b0;
            failsafe  <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (chan_we && (ADDR == AW'(i))) begin
                    shadow[i] <= wr_val;
                end
            end

            if (ctrl_we) begin
                arm <= WD[CTRL_ARM_BIT];
            end

            if (frame_start) begin
                armed_act <= arm;
                for (int i = 0; i < CHANNELS; i++) begin
                    act[i] <= failsafe ? '0 : shadow[i];
                end
            end

            if (chan_we) begin
                wd_cnt   <= '0;
                failsafe <= 1'b0;
            end else if (frame_start) begin
                wd_cnt <= wd_inc;
                if (wd_inc == WDOG_LIM) begin
                    failsafe <= 1'b1;
                end
            end
        end
    end

    // Output comparators: every channel is high from us_cnt 0 until its
    // MIN_US + value threshold, and only while the frame is armed
    always_comb begin
        ppm_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ppm_next[i] = armed_act &&
                          (32'(us_cnt) < (32'(MIN_US) + 32'(act[i])));
        end
    end

    // Outputs are registered, one cycle behind the comparator inputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ppm_q <= '0;
        end else begin
            ppm_q <= ppm_next;
        end
    end

    // Bus readback: zero-extended shadow values, the control/status word,
    // and zero for any address past the control register
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ADDR == AW'(i)) begin
                rd_data = 32'(shadow[i]);
            end
        end
        if (ADDR == CTRL_ADDR) begin
            rd_data[CTRL_ARM_BIT]             = arm;
            rd_data[CTRL_FAILSAFE_BIT]        = failsafe;
            rd_data[CTRL_ARMED_BIT]           = armed_act;
            rd_data[FRAME_CNT_LSB +: 16]      = frame_cnt;
        end
    end

    assign RD       = rd_data;
    assign PPM      = ppm_q;
    assign FAILSAFE = failsafe;

endmodule

// File: tb/tb_ppm_bank.sv
// ---------------------------------------------------------------------------
// tb_ppm_bank
// Self-checking bench for ppm_bank with a 1-clock tick and a 4000-cycle
// frame, so cycle counts equal microseconds. VAL_W is 11 so that a write of
// 2000 reaches the clamp (min(2000, 1000) = 1000). Frame starts fall on
// posedges 4000*k after reset release; PPM rises one edge later.
// ---------------------------------------------------------------------------
module tb_ppm_bank;

    localparam int CH = 4;
    localparam int AW = 3;

    typedef enum {OP_WR, OP_RD, OP_PPM, OP_FS, OP_WIDTH, OP_PERIOD} op_e;

    typedef struct {
        int          at;
        op_e         op;
        int          idx;
        logic [31:0] val;
        string       name;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic [CH-1:0] ppm;
    logic          failsafe;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    int       run_w  [CH] = '{default: 0};
    int       last_w [CH] = '{default: 0};
    logic [CH-1:0] ppm_prev = '0;
    int       last_rise = 0;
    int       prev_rise = 0;
    bit       seen_high = 0;

    vec_t vecs[$];

    ppm_bank #(
        .CHANNELS    (CH),
        .VAL_W       (11),
        .MAX_VAL     (1000),
        .TICK_DIV    (1),
        .MIN_US      (1000),
        .FRAME_US    (4000),
        .WDOG_FRAMES (3)
    ) dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .WE       (we),
        .ADDR     (addr),
        .WD       (wd),
        .RD       (rd),
        .PPM      (ppm),
        .FAILSAFE (failsafe)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Posedges since reset release; frame starts are multiples of 4000
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pulse monitor: width of the last completed pulse per channel and
    // the rise times of channel 0, all sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (ppm[i]) begin
                run_w[i] = run_w[i] + 1;
            end else if (ppm_prev[i]) begin
                last_w[i] = run_w[i];
                run_w[i]  = 0;
            end
        end
        if (ppm[0] && !ppm_prev[0]) begin
            prev_rise = last_rise;
            last_rise = cyc;
        end
        if (ppm != '0) seen_high = 1;
        ppm_prev = ppm;
    end

    function automatic void addVec(input int at, input op_e op, input int idx,
                                   input logic [31:0] val, input string name);
        vec_t v;
        v.at = at; v.op = op; v.idx = idx; v.val = val; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // One-cycle bus write, captured by the posedge after the call
    task automatic applyStimulus(input int a, input logic [31:0] d);
        we   = 1'b1;
        addr = AW'(a);
        wd   = d;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic readReg(input int a, output logic [31:0] d);
        addr = AW'(a);
        #1;
        d = rd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    initial begin
        logic [31:0] rdv;

        // Timed schedule of writes and checks (cycle = posedges since reset)
        addVec( 4000, OP_WR,     4, 32'd1,         "arm");
        addVec( 4001, OP_WR,     0, 32'd500,       "wr ch0");
        addVec( 4002, OP_WR,     3, 32'd2000,      "wr ch3");
        addVec( 4003, OP_RD,     3, 32'd1000,      "rd ch3 clamped");
        addVec( 4004, OP_RD,     0, 32'd500,       "rd ch0");
        addVec( 4005, OP_RD,     4, 32'h00010001,  "rd ctrl arm req");
        addVec( 4006, OP_RD,     5, 32'd0,         "rd unused addr");
        addVec( 4007, OP_RD,     1, 32'd0,         "rd ch1");
        addVec( 8000, OP_PPM,    0, 32'h0,         "ppm before latency");
        addVec( 8001, OP_PPM,    0, 32'hF,         "ppm all rise");
        addVec( 8002, OP_RD,     4, 32'h00020005,  "rd ctrl armed");
        addVec( 9100, OP_WR,     0, 32'd200,       "wr ch0 mid pulse");
        addVec( 9101, OP_PPM,    0, 32'h9,         "ppm ch0 ch3 high");
        addVec(10100, OP_WIDTH,  0, 32'd1500,      "width ch0 500");
        addVec(10100, OP_WIDTH,  1, 32'd1000,      "width ch1 0");
        addVec(10100, OP_WIDTH,  2, 32'd1000,      "width ch2 0");
        addVec(10100, OP_WIDTH,  3, 32'd2000,      "width ch3 clamp");
        addVec(10101, OP_RD,     0, 32'd200,       "rd ch0 new");
        addVec(12100, OP_PERIOD, 0, 32'd4000,      "frame period");
        addVec(14100, OP_WIDTH,  0, 32'd1200,      "width ch0 200");
        addVec(14100, OP_WIDTH,  3, 32'd2000,      "width ch3 again");
        addVec(15998, OP_WR,     1, 32'd300,       "wr ch1 before fs");
        addVec(15999, OP_WR,     2, 32'd300,       "wr ch2 on fs");
        addVec(18100, OP_WIDTH,  1, 32'd1300,      "width ch1 early wr");
        addVec(18100, OP_WIDTH,  2, 32'd1000,      "width ch2 fs wr old");
        addVec(22100, OP_WIDTH,  1, 32'd1300,      "width ch1 steady");
        addVec(22100, OP_WIDTH,  2, 32'd1300,      "width ch2 late");
        addVec(27999, OP_FS,     0, 32'd0,         "failsafe before trip");
        addVec(28000, OP_FS,     0, 32'd1,         "failsafe trip");
        addVec(28001, OP_RD,     4, 32'h00070007,  "rd ctrl failsafe");
        addVec(30100, OP_WIDTH,  0, 32'd1200,      "width trip frame");
        addVec(34100, OP_WIDTH,  0, 32'd1000,      "width fs ch0");
        addVec(34100, OP_WIDTH,  1, 32'd1000,      "width fs ch1");
        addVec(34100, OP_WIDTH,  2, 32'd1000,      "width fs ch2");
        addVec(34100, OP_WIDTH,  3, 32'd1000,      "width fs ch3");
        addVec(34100, OP_WR,     3, 32'd700,       "wr ch3 clears fs");
        addVec(34101, OP_FS,     0, 32'd0,         "failsafe cleared");
        addVec(38100, OP_WIDTH,  0, 32'd1200,      "width resume ch0");
        addVec(38100, OP_WIDTH,  1, 32'd1300,      "width resume ch1");
        addVec(38100, OP_WIDTH,  2, 32'd1300,      "width resume ch2");
        addVec(38100, OP_WIDTH,  3, 32'd1700,      "width resume ch3");
        addVec(43999, OP_WR,     0, 32'd200,       "wr at expiry");
        addVec(44000, OP_FS,     0, 32'd0,         "write beats expiry");
        addVec(44500, OP_WR,     4, 32'd0,         "disarm mid pulse");
        addVec(46100, OP_WIDTH,  0, 32'd1200,      "width ch0 disarm frame");
        addVec(46100, OP_WIDTH,  3, 32'd1700,      "width ch3 disarm frame");
        addVec(48000, OP_RD,     4, 32'h000C0000,  "rd ctrl disarmed");
        addVec(48001, OP_PPM,    0, 32'h0,         "ppm disarmed start");
        addVec(50000, OP_PPM,    0, 32'h0,         "ppm disarmed mid");
        addVec(50001, OP_WR,     4, 32'd1,         "rearm");

        rst_n = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wd    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset ppm", 32'(ppm), 32'h0);
        checkOutput("reset failsafe", 32'(failsafe), 32'h0);
        readReg(4, rdv);
        checkOutput("reset rd ctrl", rdv, 32'h0);
        readReg(0, rdv);
        checkOutput("reset rd ch0", rdv, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame: nothing happens until exactly 4000 cycles in
        seen_high = 0;
        waitCyc(3999);
        readReg(4, rdv);
        checkOutput("frame cnt before fs1", rdv, 32'h0);
        waitCyc(4000);
        readReg(4, rdv);
        checkOutput("frame cnt at fs1", rdv, 32'h00010000);
        checkOutput("ppm low first frame", 32'(seen_high), 32'h0);
        checkOutput("failsafe first frame", 32'(failsafe), 32'h0);

        foreach (vecs[k]) begin
            waitCyc(vecs[k].at);
            case (vecs[k].op)
                OP_WR:     applyStimulus(vecs[k].idx, vecs[k].val);
                OP_RD: begin
                    readReg(vecs[k].idx, rdv);
                    checkOutput(vecs[k].name, rdv, vecs[k].val);
                end
                OP_PPM:    checkOutput(vecs[k].name, 32'(ppm), vecs[k].val);
                OP_FS:     checkOutput(vecs[k].name, 32'(failsafe), vecs[k].val);
                OP_WIDTH:  checkOutput(vecs[k].name, 32'(last_w[vecs[k].idx]), vecs[k].val);
                OP_PERIOD: checkOutput(vecs[k].name, 32'(last_rise - prev_rise), vecs[k].val);
                default:   checkOutput("bad op", 32'd1, 32'd0);
            endcase
        end

        // Re-armed frame, then reset in the middle of the pulse
        waitCyc(52300);
        checkOutput("ppm rearmed", 32'(ppm), 32'hF);
        rst_n = 1'b0;
        #1;
        checkOutput("ppm async reset", 32'(ppm), 32'h0);
        checkOutput("failsafe async reset", 32'(failsafe), 32'h0);
        for (int a = 0; a <= CH; a++) begin
            readReg(a, rdv);
            checkOutput($sformatf("rd %0d after reset", a), rdv, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppm_bank.md
# ppm_bank

Parametrised multi-channel PPM/servo pulse generator that replaces the fixed four-engine output path (two 32-bit engine registers feeding four single-channel PPM generators). It sits on the CPU data bus behind the bus controller and drives the engine/servo pins directly. Beyond the existing path, it adds frame-synchronous value updates, value clamping, an arm control, and a write-watchdog failsafe that forces all channels to minimum throttle.

## Interface
- CHANNELS, 4, number of PPM outputs (1..16)
- VAL_W, 10, width of a channel value
- MAX_VAL, 1000, values above this are clamped to it
- TICK_DIV, 50, CLK cycles per 1 µs tick (≥1)
- MIN_US, 1000, pulse width in µs for value 0
- FRAME_US, 20000, frame period in µs; must exceed MIN_US+MAX_VAL (elaboration error otherwise)
- WDOG_FRAMES, 25, consecutive frames without a channel write before failsafe (≥1)
- Derived: AW = $clog2(CHANNELS+1)

Ports:
- CLK  in  1  CPU clock; sole clock
- RESET_N  in  1  asynchronous, active-low reset
- WE  in  1  bus write strobe, one cycle per write
- ADDR  in  AW  0..CHANNELS-1 = channel value registers; CHANNELS = control/status register
- WD  in  32  write data
- RD  out  32  combinational read data for ADDR
- PPM  out  CHANNELS  pulse outputs, registered
- FAILSAFE  out  1  high while the watchdog has tripped

## Operation
- Shadow registers, one per channel: a write to channel i stores min(WD[VAL_W-1:0], MAX_VAL). Shadows are written at any time.
- Active registers: at each frame start, all shadows are copied to the active registers and the control register ARM is copied to armed_act. A pulse therefore never changes mid-frame.
- Control register, bit 0 = ARM (R/W). Status readback fields:
  - bit 1 = FAILSAFE (RO)
  - bit 2 = armed_act (RO)
  - bits 31:16 = frame counter modulo 2^16 (RO)
- Reading a channel address returns the zero-extended shadow value. Reading an unused address returns 0.
- Timebase:
  - A prescaler counts 0..TICK_DIV-1; a tick occurs at TICK_DIV-1.
  - us_cnt advances on each tick and runs 0..FRAME_US-1, then wraps.
  - Frame start is the tick on which us_cnt wraps to 0.
- Output rule: PPM[i] = armed_act && us_cnt < MIN_US + act_val[i]. All channels rise together at frame start.
- Disarmed state: PPM is held low for the whole frame. Disarm takes effect at the next frame start, so the current pulse completes.
- Watchdog:
  - wd_cnt increments at each frame start and clears on any channel write. Writes to the control register do not clear it.
  - When wd_cnt reaches WDOG_FRAMES, FAILSAFE is set. While FAILSAFE is set, the frame latch loads 0 into every active register regardless of the shadows.
  - FAILSAFE clears on the next channel write. Normal values resume at the following frame start.
- Simultaneous events:
  - A write on the same cycle as the frame latch is not seen; the latch takes the old shadow and the new value applies one frame later.
  - A channel write on the same cycle as watchdog expiry wins: wd_cnt clears and FAILSAFE stays 0.
- Reset mid-frame: all state clears immediately and PPM drops the same cycle (asynchronous reset).

## Timing
- Reset values:
  - PPM = 0, FAILSAFE = 0, RD reflects cleared registers.
  - All shadow, active, ARM, armed_act, prescaler, us_cnt, wd_cnt and frame counter registers = 0.
- Write latency: a register is updated at the CLK edge where WE=1. RD shows the new value from the next cycle.
- PPM latency: one CLK cycle after the us_cnt/active-register change that causes it.
- Pulse width: exactly (MIN_US + val) × TICK_DIV CLK cycles.
- Frame period: exactly FRAME_US × TICK_DIV CLK cycles.
- First frame start after reset occurs FRAME_US × TICK_DIV cycles after reset deasserts. Outputs stay low until then.

## Structure
- Package ppm_pkg holds:
  - Control-register bit positions: ARM=0, FAILSAFE=1, ARMED=2.
  - Frame counter field offset: 16.
  - Register-offset constant for the control register (= CHANNELS).
- Sub-module ppm_timebase contains the prescaler, us_cnt, frame_start pulse and 16-bit frame counter. It is parametrised by TICK_DIV and FRAME_US.
- The top level holds the register file, clamping, watchdog and output comparators. It replaces both engine registers and the four single-channel PPM instances in the system top level.

## Test plan
Bench parameters: TICK_DIV=1, FRAME_US=4000, MIN_US=1000, MAX_VAL=1000, WDOG_FRAMES=3, CHANNELS=4.
- Reset then no writes → PPM=0 and FAILSAFE=0 for the first frame. RD at ADDR 4 reads 0.
- Arm, write ch0=500 and ch3=2000 → from the 2nd frame start: ch0 high 1500 cycles, ch3 high 2000 cycles (clamped; readback 1000), ch1 and ch2 high 1000 cycles. Period is 4000 cycles.
- Write ch0=200 at us_cnt=1100 while ch0 is high with value 500 → the current pulse still ends at 1500. The next frame pulse is 1200.
- Write exactly on the frame-start cycle → the new value appears one frame later than for a write one cycle earlier.
- Arm and write values, then stop writing → FAILSAFE rises at the 3rd frame start. All pulses are 1000 cycles from the following frame. One write clears FAILSAFE, and the value resumes at the next frame.
- Clear ARM mid-pulse → the current pulse completes and the next frame is all-low. Assert RESET_N=0 mid-pulse → PPM drops the same cycle and all registers read 0.
